// File: rtl/rv_warp_issue_arbiter_pkg.sv
// rv_warp_issue_arbiter_pkg: shared warp/ex-unit sizing and execution-unit codes
package rv_warp_issue_arbiter_pkg;
  localparam int NUM_WARPS = 4;
  localparam int NW_BITS   = $clog2(NUM_WARPS);
  localparam int EX_BITS   = 3;
  localparam logic [EX_BITS-1:0] EX_ALU = 3'd0;
  localparam logic [EX_BITS-1:0] EX_LSU = 3'd1;
  localparam logic [EX_BITS-1:0] EX_CSR = 3'd2;
  localparam logic [EX_BITS-1:0] EX_FPU = 3'd3;
  localparam logic [EX_BITS-1:0] EX_GPU = 3'd4;
endpackage

// File: rtl/rv_warp_issue_arbiter_if.sv
// rv_warp_issue_arbiter_if: ibuffer stream from the warp scheduler toward dispatch
interface rv_warp_issue_arbiter_if #(
  parameter int NW    = 2,
  parameter int DATAW = 128
);
  logic             valid;
  logic [NW-1:0]    wid;
  logic [DATAW-1:0] data;
  logic             ready;
  modport master (output valid, wid, data, input ready);
  modport slave  (input valid, wid, data, output ready);
endinterface

// File: rtl/rv_rr_picker.sv
// rv_rr_picker: combinational round-robin pick of the first request after last_wid
module rv_rr_picker #(
  parameter int NUM_WARPS = 4,
  localparam int NW = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0] req,
  input  logic [NW-1:0]        last_wid,
  output logic [NUM_WARPS-1:0] grant,
  output logic [NW-1:0]        wid,
  output logic                 any
);
  always_comb begin
    grant = '0;
    wid   = '0;
    any   = 1'b0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      if (!any && req[(int'(last_wid) + i) % NUM_WARPS]) begin
        any = 1'b1;
        wid = NW'((int'(last_wid) + i) % NUM_WARPS);
        grant[(int'(last_wid) + i) % NUM_WARPS] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rv_warp_issue_arbiter.sv
// rv_warp_issue_arbiter: per-cycle warp pick (round-robin + starvation boost)
// feeding one registered ibuffer output stage.
module rv_warp_issue_arbiter
  import rv_warp_issue_arbiter_pkg::*;
#(
  parameter int NUM_WARPS    = rv_warp_issue_arbiter_pkg::NUM_WARPS,
  parameter int DATAW        = 128,
  parameter int STARVE_LIMIT = 16,
  localparam int NW = $clog2(NUM_WARPS),
  localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WARPS-1:0]         in_valid,
  input  logic [NUM_WARPS*DATAW-1:0]   in_data,
  input  logic [NUM_WARPS*EX_BITS-1:0] in_ex_type,
  input  logic [NUM_WARPS-1:0]         sb_ready,
  input  logic [2**EX_BITS-1:0]        unit_ready,
  output logic [NUM_WARPS-1:0]         in_ready,
  rv_warp_issue_arbiter_if.master      ibuf,
  output logic [31:0]                  perf_stall
);
  logic             valid_q, valid_d;
  logic [NW-1:0]    wid_q, wid_d, last_q, last_d;
  logic [DATAW-1:0] data_q, data_d;
  logic [31:0]      perf_q, perf_d;
  logic [CW-1:0]    wait_q [NUM_WARPS];
  logic [CW-1:0]    wait_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] elig, starved, rr_grant, sv_grant, grant_sel;
  logic [NW-1:0]    rr_wid, sv_wid, wid_sel;
  logic             rr_any, sv_any, load, fire;
  always_comb begin
    elig    = '0;
    starved = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w]    = in_valid[w] & sb_ready[w] & unit_ready[in_ex_type[w*EX_BITS +: EX_BITS]];
      starved[w] = elig[w] & (wait_q[w] == CW'(STARVE_LIMIT));
    end
  end
  rv_rr_picker #(.NUM_WARPS(NUM_WARPS)) u_rr (
    .req(elig), .last_wid(last_q), .grant(rr_grant), .wid(rr_wid), .any(rr_any)
  );
  // Fixed last_wid of NUM_WARPS-1 turns the picker into a lowest-index-first search.
  rv_rr_picker #(.NUM_WARPS(NUM_WARPS)) u_sv (
    .req(starved), .last_wid(NW'(NUM_WARPS - 1)), .grant(sv_grant), .wid(sv_wid), .any(sv_any)
  );
  always_comb begin
    load      = ~valid_q | ibuf.ready;
    fire      = load & rr_any;
    grant_sel = sv_any ? sv_grant : rr_grant;
    wid_sel   = sv_any ? sv_wid : rr_wid;
    in_ready  = (fire & reset) ? grant_sel : '0;
    valid_d   = load ? rr_any : valid_q;
    wid_d     = fire ? wid_sel : wid_q;
    data_d    = fire ? in_data[wid_sel*DATAW +: DATAW] : data_q;
    last_d    = (fire & ~sv_any) ? rr_wid : last_q;
    perf_d    = perf_q + {31'd0, (|in_valid) & ~fire};
    for (int w = 0; w < NUM_WARPS; w++)
      wait_d[w] = (in_ready[w] | ~in_valid[w]) ? '0 :
                  (elig[w] & (load | valid_q) & (wait_q[w] != CW'(STARVE_LIMIT))) ? wait_q[w] + 1'b1 :
                  wait_q[w];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      wid_q   <= '0;
      data_q  <= '0;
      last_q  <= NW'(NUM_WARPS - 1);
      perf_q  <= '0;
      for (int w = 0; w < NUM_WARPS; w++) wait_q[w] <= '0;
    end else begin
      valid_q <= valid_d;
      wid_q   <= wid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      perf_q  <= perf_d;
      for (int w = 0; w < NUM_WARPS; w++) wait_q[w] <= wait_d[w];
    end
  end
  assign ibuf.valid = valid_q;
  assign ibuf.wid   = wid_q;
  assign ibuf.data  = data_q;
  assign perf_stall = perf_q;
endmodule

// File: tb/tb_rv_warp_issue_arbiter.sv
// tb_rv_warp_issue_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural scheduler model.
module tb_rv_warp_issue_arbiter;
  import rv_warp_issue_arbiter_pkg::*;
  localparam int N = 4, DW = 16, LIM = 4;
  logic            clk = 1'b0, reset = 1'b0;
  logic [N-1:0]    in_valid = '0, sb_ready = '0, in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic [N*3-1:0]  in_ex_type = '0;
  logic [7:0]      unit_ready = '1;
  logic [31:0]     perf_stall;
  int total = 0, bad = 0;
  bit m_valid;
  int m_wid, m_last, m_perf, m_wait[N];
  logic [DW-1:0] m_data;
  rv_warp_issue_arbiter_if #(.NW(2), .DATAW(DW)) ibuf ();
  rv_warp_issue_arbiter #(.NUM_WARPS(N), .DATAW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ex_type(in_ex_type), .sb_ready(sb_ready), .unit_ready(unit_ready),
    .in_ready(in_ready), .ibuf(ibuf), .perf_stall(perf_stall)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_valid = 0; m_wid = 0; m_data = '0; m_last = N - 1; m_perf = 0;
    for (int w = 0; w < N; w++) m_wait[w] = 0;
  endtask
  task automatic chk_regs();
    chk("out_valid", 64'(ibuf.valid), 64'(m_valid));
    chk("out_wid", 64'(ibuf.wid), 64'(m_wid));
    chk("out_data", 64'(ibuf.data), 64'(m_data));
    chk("perf_stall", 64'(perf_stall), 64'(m_perf));
    for (int w = 0; w < N; w++) chk($sformatf("wait_cnt%0d", w), 64'(dut.wait_q[w]), 64'(m_wait[w]));
  endtask
  // Inputs are set at the negedge before the call; returns at the following negedge.
  task automatic tick(output int gw);
    logic [N-1:0] el, er;
    bit ld, sv;
    int g;
    for (int w = 0; w < N; w++) el[w] = in_valid[w] & sb_ready[w] & unit_ready[in_ex_type[w*3 +: 3]];
    ld = !m_valid || ibuf.ready;
    g = -1;
    for (int w = 0; w < N; w++) if (g < 0 && el[w] && m_wait[w] == LIM) g = w;
    sv = g >= 0;
    for (int k = 1; k <= N; k++) if (g < 0 && el[(m_last + k) % N]) g = (m_last + k) % N;
    if (!ld) g = -1;
    er = (g >= 0) ? 4'(1 << g) : 4'd0;
    gw = g;
    #1 chk("in_ready", 64'(in_ready), 64'(er));
    @(posedge clk);
    if ((|in_valid) && g < 0) m_perf++;
    for (int w = 0; w < N; w++)
      if (er[w] || !in_valid[w]) m_wait[w] = 0;
      else if (el[w] && m_wait[w] < LIM) m_wait[w]++;
    if (ld) begin
      m_valid = g >= 0;
      if (g >= 0) begin
        m_wid = g;
        m_data = in_data[g*DW +: DW];
        if (!sv) m_last = g;
      end
    end
    #1 chk_regs();
    @(negedge clk);
  endtask
  task automatic rand_data();
    for (int w = 0; w < N; w++) in_data[w*DW +: DW] = DW'($urandom);
  endtask
  initial begin
    int g;
    model_reset();
    in_valid = '1; sb_ready = '1; unit_ready = '1; ibuf.ready = 1'b1; rand_data();
    repeat (2) @(posedge clk);
    #1 chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(ibuf.valid), 64'd0);
    chk_regs();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      tick(g);
      chk("t1_order", 64'(g), 64'(i % N));
    end
    ibuf.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_data(); tick(g); end
    ibuf.ready = 1'b1;
    tick(g);
    sb_ready = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      tick(g);
      chk("t3_w1_blocked", 64'(g == 1), 64'd0);
    end
    sb_ready = '1;
    in_ex_type = {4{EX_LSU}};
    unit_ready[EX_LSU] = 1'b0;
    for (int i = 0; i < 5; i++) begin rand_data(); tick(g); end
    unit_ready = '1;
    in_ex_type = '0;
    for (int i = 0; i < 4000; i++) begin
      rand_data();
      in_valid = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      sb_ready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      if (i % 500 < 250) sb_ready[3] = i[0];
      for (int w = 0; w < N; w++) in_ex_type[w*3 +: 3] = 3'($urandom_range(0, 7));
      unit_ready = 8'($urandom) | 8'($urandom);
      ibuf.ready = ($urandom_range(0, 3) != 0);
      tick(g);
    end
    in_valid = '1; sb_ready = '1; unit_ready = '1; ibuf.ready = 1'b0;
    tick(g);
    chk("t6_pre_valid", 64'(ibuf.valid), 64'd1);
    #2 reset = 1'b0;
    model_reset();
    #1 chk("t6_async_valid", 64'(ibuf.valid), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    chk_regs();
    @(negedge clk) reset = 1'b1;
    ibuf.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      tick(g);
      chk("t6_restart_order", 64'(g), 64'(i % N));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
